// File: rtl/psec_ch_ctrl_if.sv
// Host-side bus of the PSEC channel controller: command channel and
// readout-word channel.
//
// Handshake semantics (both channels): a transfer happens on the rising CLK
// edge where VALID and READY are both high. The source holds VALID and its
// payload (CMD_OP, or DATA/DATA_SEL) stable until that edge. READY never
// depends combinationally on VALID. CMD_ERR is a one-cycle pulse following
// acceptance of a command that is illegal in the current state.
interface psec_ch_ctrl_if #(
    parameter int WORD_W = 10
);
    logic              CMD_VALID;
    logic [1:0]        CMD_OP;
    logic              CMD_READY;
    logic              CMD_ERR;
    logic              DATA_VALID;
    logic              DATA_READY;
    logic [WORD_W-1:0] DATA;
    logic [2:0]        DATA_SEL;

    // Host side
    modport master (
        output CMD_VALID, CMD_OP, DATA_READY,
        input  CMD_READY, CMD_ERR, DATA_VALID, DATA, DATA_SEL
    );

    // Controller side
    modport slave (
        input  CMD_VALID, CMD_OP, DATA_READY,
        output CMD_READY, CMD_ERR, DATA_VALID, DATA, DATA_SEL
    );
endinterface

// File: rtl/psec_ch_ctrl.sv
// PSEC channel controller: arms/stops a sampling channel with two-cycle
// instruction pulses and reads back its registers over a CLK/2 serial link.
// STATE_DBG exposes the FSM state for checkers.
module psec_ch_ctrl #(
    parameter int WORD_W    = 10,   // bits per serial word, must be >= 2
    parameter int NREG      = 6,    // registers read per readout
    parameter int AUTO_STOP = 1     // stop on synchronized STOP_REQUEST edge
) (
    input  logic       CLK,
    input  logic       RSTB,
    psec_ch_ctrl_if.slave host,
    input  logic       STOP_REQUEST,
    input  logic       CNT_SER,
    output logic       INST_START,
    output logic       INST_STOP,
    output logic       INST_READOUT,
    output logic [2:0] SELECT_REG,
    output logic       SPI_CLK,
    output logic       BUSY,
    output logic [3:0] STATE_DBG
);

    localparam int BW = $clog2(WORD_W);

    localparam logic [1:0] OP_START   = 2'b00;
    localparam logic [1:0] OP_STOP    = 2'b01;
    localparam logic [1:0] OP_READOUT = 2'b10;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START_P = 4'd1,
        ARMED   = 4'd2,
        STOP_P  = 4'd3,
        STOPPED = 4'd4,
        SEL     = 4'd5,
        RD_P    = 4'd6,
        SHIFT   = 4'd7,
        PUSH    = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;         // second cycle of a 2-cycle step
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]        k_q, k_d;                 // register index being read
    logic [2:0]        sel_q, sel_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [2:0]        data_sel_q, data_sel_d;
    logic              data_valid_q, data_valid_d;
    logic              spi_clk_q, spi_clk_d;
    logic              inst_start_q, inst_start_d;
    logic              inst_stop_q, inst_stop_d;
    logic              inst_readout_q, inst_readout_d;
    logic              cmd_err_q, cmd_err_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic              rst_done_q;

    logic              idle_like;
    logic              cmd_ready;
    logic              cmd_acc;
    logic              stop_edge;
    logic [WORD_W-1:0] shift_in;

    // Commands are only taken in the resting states, and never in the
    // first cycle after reset release.
    assign idle_like = (state_q == IDLE) || (state_q == ARMED) || (state_q == STOPPED);
    assign cmd_ready = rst_done_q && idle_like;
    assign cmd_acc   = host.CMD_VALID && cmd_ready;
    assign stop_edge = sync2_q && !sync3_q;
    assign shift_in  = {shreg_q[WORD_W-2:0], CNT_SER};

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        phase_d    = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        k_d        = k_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        data_sel_d = data_sel_q;
        spi_clk_d  = 1'b0;
        cmd_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    if (host.CMD_OP == OP_START) state_d = START_P;
                    else                         cmd_err_d = 1'b1;
                end
            end
            START_P: begin
                if (phase_q) state_d = ARMED;
                else         phase_d = 1'b1;
            end
            ARMED: begin
                // Host STOP and an auto-stop edge in the same cycle merge
                // into one STOP_P sequence.
                if (cmd_acc && host.CMD_OP == OP_STOP) begin
                    state_d = STOP_P;
                end else begin
                    if (cmd_acc) cmd_err_d = 1'b1;
                    if ((AUTO_STOP != 0) && stop_edge) state_d = STOP_P;
                end
            end
            STOP_P: begin
                if (phase_q) state_d = STOPPED;
                else         phase_d = 1'b1;
            end
            STOPPED: begin
                if (cmd_acc) begin
                    case (host.CMD_OP)
                        OP_START:   state_d = START_P;
                        OP_READOUT: begin
                            state_d = SEL;
                            k_d     = 3'd0;
                        end
                        default:    cmd_err_d = 1'b1;
                    endcase
                end
            end
            SEL: begin
                if (phase_q) state_d = RD_P;
                else         phase_d = 1'b1;
            end
            RD_P: begin
                if (phase_q) begin
                    state_d   = SHIFT;
                    spi_clk_d = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    phase_d = 1'b1;
                end
            end
            SHIFT: begin
                // Sample mid-bit, on the edge where SPI_CLK falls.
                if (!spi_clk_q) begin
                    spi_clk_d = 1'b1;
                end else begin
                    shreg_d = shift_in;
                    if (bit_cnt_q == BW'(WORD_W - 1)) begin
                        state_d    = PUSH;
                        data_d     = shift_in;
                        data_sel_d = k_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PUSH: begin
                if (host.DATA_READY) begin
                    if (k_q == 3'(NREG - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = SEL;
                    end
                end
            end
            DONE:    state_d = STOPPED;
            default: state_d = IDLE;
        endcase

        sel_d          = (state_d == SEL) ? k_d : sel_q;
        inst_start_d   = (state_d == START_P);
        inst_stop_d    = (state_d == STOP_P);
        inst_readout_d = (state_d == RD_P);
        data_valid_d   = (state_d == PUSH);
    end

    // State and output registers, async active-low reset
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q        <= IDLE;
            phase_q        <= 1'b0;
            bit_cnt_q      <= '0;
            k_q            <= 3'd0;
            sel_q          <= 3'd0;
            shreg_q        <= '0;
            data_q         <= '0;
            data_sel_q     <= 3'd0;
            data_valid_q   <= 1'b0;
            spi_clk_q      <= 1'b0;
            inst_start_q   <= 1'b0;
            inst_stop_q    <= 1'b0;
            inst_readout_q <= 1'b0;
            cmd_err_q      <= 1'b0;
            rst_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            bit_cnt_q      <= bit_cnt_d;
            k_q            <= k_d;
            sel_q          <= sel_d;
            shreg_q        <= shreg_d;
            data_q         <= data_d;
            data_sel_q     <= data_sel_d;
            data_valid_q   <= data_valid_d;
            spi_clk_q      <= spi_clk_d;
            inst_start_q   <= inst_start_d;
            inst_stop_q    <= inst_stop_d;
            inst_readout_q <= inst_readout_d;
            cmd_err_q      <= cmd_err_d;
            rst_done_q     <= 1'b1;
        end
    end

    // STOP_REQUEST synchronizer plus edge-detect stage; runs in every state
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= STOP_REQUEST;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign host.CMD_READY  = cmd_ready;
    assign host.CMD_ERR    = cmd_err_q;
    assign host.DATA_VALID = data_valid_q;
    assign host.DATA       = data_q;
    assign host.DATA_SEL   = data_sel_q;
    assign INST_START      = inst_start_q;
    assign INST_STOP       = inst_stop_q;
    assign INST_READOUT    = inst_readout_q;
    assign SELECT_REG      = sel_q;
    assign SPI_CLK         = spi_clk_q;
    assign BUSY            = !idle_like;
    assign STATE_DBG       = state_q;

endmodule

// File: tb/tb_psec_ch_ctrl.sv
// Directed bench for psec_ch_ctrl with a behavioural channel model.
module tb_psec_ch_ctrl;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ARMED   = 4'd2;
    localparam logic [3:0] S_STOPPED = 4'd4;
    localparam logic [3:0] S_DONE    = 4'd9;

    logic       clk = 1'b0;
    logic       rstb;
    logic       stop_request;
    logic       cnt_ser = 1'b0;
    logic       inst_start, inst_stop, inst_readout;
    logic [2:0] select_reg;
    logic       spi_clk, busy;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    psec_ch_ctrl_if #(.WORD_W(10)) bus ();

    psec_ch_ctrl #(.WORD_W(10), .NREG(6), .AUTO_STOP(1)) dut (
        .CLK          (clk),
        .RSTB         (rstb),
        .host         (bus),
        .STOP_REQUEST (stop_request),
        .CNT_SER      (cnt_ser),
        .INST_START   (inst_start),
        .INST_STOP    (inst_stop),
        .INST_READOUT (inst_readout),
        .SELECT_REG   (select_reg),
        .SPI_CLK      (spi_clk),
        .BUSY         (busy),
        .STATE_DBG    (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // channel model: latches the selected register on INST_READOUT, shifts
    // MSB first after each SPI_CLK rising edge
    logic [9:0] ch_reg [8];
    logic [9:0] ch_sh = '0;
    int         spi_rises = 0;
    always @(posedge inst_readout or posedge spi_clk) begin
        if (spi_clk) begin
            cnt_ser   = ch_sh[9];
            ch_sh     = {ch_sh[8:0], 1'b0};
            spi_rises = spi_rises + 1;
        end else begin
            ch_sh = ch_reg[select_reg];
        end
    end

    // instruction pulses must never overlap
    logic excl_bad = 1'b0;
    always @(negedge clk) begin
        if ((int'(inst_start) + int'(inst_stop) + int'(inst_readout)) > 1) excl_bad = 1'b1;
    end

    // scoreboard
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // driver: present a command until accepted
    task automatic send_cmd(input logic [1:0] op);
        int t;
        t = 0;
        @(negedge clk);
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        while (!bus.CMD_READY && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept_in_time", 32'(t < 50), 32'd1);
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_word();
        int t;
        t = 0;
        while (!bus.DATA_VALID && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("word_valid_in_time", 32'(bus.DATA_VALID), 32'd1);
    endtask

    task automatic handshake();
        bus.DATA_READY = 1'b1;
        @(negedge clk);
        bus.DATA_READY = 1'b0;
    endtask

    initial begin
        int         i;
        int         base;
        logic [9:0] exp_w;
        logic [9:0] hold_data;
        logic       bad;

        rstb = 1'b0;
        stop_request = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP = 2'b00;
        bus.DATA_READY = 1'b0;
        ch_reg[0] = 10'h2A5; ch_reg[1] = 10'h155; ch_reg[2] = 10'h000;
        ch_reg[3] = 10'h3FF; ch_reg[4] = 10'h001; ch_reg[5] = 10'h003;
        ch_reg[6] = 10'h000; ch_reg[7] = 10'h000;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_inst_start", 32'(inst_start), 0);
        check("rst_inst_stop", 32'(inst_stop), 0);
        check("rst_inst_readout", 32'(inst_readout), 0);
        check("rst_spi_clk", 32'(spi_clk), 0);
        check("rst_select", 32'(select_reg), 0);
        check("rst_data", 32'(bus.DATA), 0);
        check("rst_data_valid", 32'(bus.DATA_VALID), 0);
        check("rst_cmd_err", 32'(bus.CMD_ERR), 0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        rstb = 1'b1;
        #1 check("ready_first_cycle", 32'(bus.CMD_READY), 0);
        @(negedge clk);
        check("ready_after_release", 32'(bus.CMD_READY), 1);

        // reserved op in IDLE
        send_cmd(2'b11);
        check("op11_err", 32'(bus.CMD_ERR), 1);
        check("op11_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        check("op11_err_pulse", 32'(bus.CMD_ERR), 0);

        // START
        send_cmd(2'b00);
        check("start_p1", 32'(inst_start), 1);
        check("start_busy", 32'(busy), 1);
        check("start_not_ready", 32'(bus.CMD_READY), 0);
        @(negedge clk);
        check("start_p2", 32'(inst_start), 1);
        @(negedge clk);
        check("start_end", 32'(inst_start), 0);
        check("armed_state", 32'(state_dbg), 32'(S_ARMED));
        check("armed_ready", 32'(bus.CMD_READY), 1);

        // READOUT in ARMED is illegal
        send_cmd(2'b10);
        check("rd_armed_err", 32'(bus.CMD_ERR), 1);
        check("rd_armed_state", 32'(state_dbg), 32'(S_ARMED));
        @(negedge clk);

        // async STOP_REQUEST, 3 clocks wide
        #1 stop_request = 1'b1;
        i = 0;
        while (!inst_stop && i < 10) begin
            @(negedge clk);
            i++;
            if (i == 3) stop_request = 1'b0;
        end
        stop_request = 1'b0;
        check("stop_latency_3_4", 32'(i >= 3 && i <= 4), 1);
        @(negedge clk);
        check("stop_p2", 32'(inst_stop), 1);
        @(negedge clk);
        check("stop_end", 32'(inst_stop), 0);
        check("stopped_state", 32'(state_dbg), 32'(S_STOPPED));

        // STOP_REQUEST outside ARMED is ignored
        stop_request = 1'b1;
        repeat (4) @(negedge clk);
        stop_request = 1'b0;
        repeat (4) @(negedge clk);
        check("req_ignored_state", 32'(state_dbg), 32'(S_STOPPED));

        // STOP in STOPPED is illegal
        send_cmd(2'b01);
        check("stop_stopped_err", 32'(bus.CMD_ERR), 1);
        check("stop_stopped_state", 32'(state_dbg), 32'(S_STOPPED));

        // full readout
        exp_q.push_back(10'h2A5); exp_q.push_back(10'h155); exp_q.push_back(10'h000);
        exp_q.push_back(10'h3FF); exp_q.push_back(10'h001); exp_q.push_back(10'h003);
        base = spi_rises;
        send_cmd(2'b10);
        for (int w = 0; w < 6; w++) begin
            wait_word();
            exp_w = exp_q.pop_front();
            check($sformatf("word%0d_data", w), 32'(bus.DATA), 32'(exp_w));
            check($sformatf("word%0d_sel", w), 32'(bus.DATA_SEL), 32'(w));
            check($sformatf("word%0d_select_reg", w), 32'(select_reg), 32'(w));
            check($sformatf("word%0d_spi_rises", w), 32'(spi_rises - base), 32'd10);
            check($sformatf("word%0d_spi_low", w), 32'(spi_clk), 0);
            if (w == 2) begin
                hold_data = bus.DATA;
                bad = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (bus.DATA !== hold_data || bus.DATA_SEL !== 3'd2 ||
                        bus.DATA_VALID !== 1'b1 || spi_clk !== 1'b0 ||
                        inst_readout !== 1'b0) bad = 1'b1;
                end
                check("stall_stable", 32'(bad), 0);
            end
            handshake();
            base = spi_rises;
        end
        check("done_state", 32'(state_dbg), 32'(S_DONE));
        @(negedge clk);
        check("back_stopped", 32'(state_dbg), 32'(S_STOPPED));
        check("back_ready", 32'(bus.CMD_READY), 1);

        // reset during 5th bit of word 1
        send_cmd(2'b10);
        wait_word();
        handshake();
        base = spi_rises;
        i = 0;
        while ((spi_rises - base) < 5 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("reached_bit5", 32'(spi_rises - base), 32'd5);
        #2 rstb = 1'b0;
        #1;
        check("mid_rst_spi_clk", 32'(spi_clk), 0);
        check("mid_rst_inst_readout", 32'(inst_readout), 0);
        check("mid_rst_select", 32'(select_reg), 0);
        check("mid_rst_data", 32'(bus.DATA), 0);
        check("mid_rst_data_sel", 32'(bus.DATA_SEL), 0);
        check("mid_rst_valid", 32'(bus.DATA_VALID), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
        bad = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.DATA_VALID !== 1'b0) bad = 1'b1;
        end
        check("no_partial_word", 32'(bad), 0);

        check("inst_exclusive", 32'(excl_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
